// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32I (+optional M) decode stage.
// The stage decodes one instruction per accepted beat. It holds the result
// in an output register, and can also hold one more beat in a skid register
// so that in_ready comes straight from a flop.

module decode_stage #(
  parameter int PC_WIDTH       = 32,
  parameter int ENABLE_M       = 0,
  parameter int ENABLE_ILLEGAL = 1,
  parameter int SKID           = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_write_en,
  output logic [4:0]          out_write_addr,
  output logic [4:0]          out_read_addr1,
  output logic [4:0]          out_read_addr2,
  output logic [31:0]         out_immediate,
  output logic                out_mem_write_en,
  output logic                out_mem_read_en,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic [4:0]          out_alu_opcode,
  output logic                out_alu_src2_from_imm,
  output logic                out_alu_src1_from_pc,
  output logic                out_branch_inst,
  output logic                out_jump_inst,
  output logic                out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam bit M_EN   = (ENABLE_M != 0);
  localparam bit ILL_EN = (ENABLE_ILLEGAL != 0);

  // One decoded beat as it sits in the output or skid register.
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                write_en;
    logic [4:0]          write_addr;
    logic [4:0]          read_addr1;
    logic [4:0]          read_addr2;
    logic [31:0]         immediate;
    logic                mem_write_en;
    logic                mem_read_en;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          alu_opcode;
    logic                alu_src2_from_imm;
    logic                alu_src1_from_pc;
    logic                branch_inst;
    logic                jump_inst;
    logic                illegal;
  } beat_t;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming instruction word
  // ---------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd     = in_inst[11:7];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic        dec_known;
  logic        dec_bad;
  logic        dec_rd_writes;
  logic        dec_load;
  logic        dec_store;
  logic        dec_branch;
  logic        dec_jump;
  logic        dec_src1_pc;
  logic        dec_src2_imm;
  logic        dec_muldiv;
  logic [4:0]  dec_alu_op;
  logic [4:0]  dec_rs1;
  logic [31:0] dec_imm;

  // Classify the opcode, pick the immediate format and flag bad encodings.
  always_comb begin
    dec_known     = 1'b0;
    dec_bad       = 1'b0;
    dec_rd_writes = 1'b0;
    dec_load      = 1'b0;
    dec_store     = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;
    dec_src1_pc   = 1'b0;
    dec_src2_imm  = 1'b1;
    dec_muldiv    = 1'b0;
    dec_alu_op    = 5'd0;
    dec_rs1       = in_inst[19:15];
    dec_imm       = 32'd0;
    case (opcode)
      OP_LUI: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_imm       = imm_u;
        dec_rs1       = 5'd0;
      end
      OP_AUIPC: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_imm       = imm_u;
        dec_src1_pc   = 1'b1;
      end
      OP_JAL: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = imm_j;
        dec_src1_pc   = 1'b1;
      end
      OP_JALR: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_jump      = 1'b1;
        dec_imm       = imm_i;
        dec_bad       = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        dec_known    = 1'b1;
        dec_branch   = 1'b1;
        dec_imm      = imm_b;
        dec_src2_imm = 1'b0;
        dec_alu_op   = {2'b00, funct3};
        dec_bad      = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_load      = 1'b1;
        dec_imm       = imm_i;
        dec_bad       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec_known = 1'b1;
        dec_store = 1'b1;
        dec_imm   = imm_s;
        dec_bad   = (funct3 > 3'b010);
      end
      OP_IMM: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_imm       = imm_i;
        // Only the right shifts carry an arithmetic/logical select in bit 30.
        dec_alu_op    = {1'b0, (funct3 == 3'b101) & in_inst[30], funct3};
        if (funct3 == 3'b001) begin
          dec_bad = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OP_REG: begin
        dec_known     = 1'b1;
        dec_rd_writes = 1'b1;
        dec_src2_imm  = 1'b0;
        case (funct7)
          7'b0000000: dec_bad = 1'b0;
          7'b0100000: dec_bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
          7'b0000001: begin
            if (M_EN) begin
              dec_muldiv = 1'b1;
            end else begin
              dec_bad = 1'b1;
            end
          end
          default:    dec_bad = 1'b1;
        endcase
        dec_alu_op = {dec_muldiv, in_inst[30], funct3};
      end
      default: dec_known = 1'b0;
    endcase
    if (!dec_known || (in_inst[1:0] != 2'b11)) begin
      dec_bad = 1'b1;
    end
  end

  logic  dec_illegal;
  beat_t dec;

  assign dec_illegal = ILL_EN & dec_bad;

  // Assemble the beat; an illegal instruction must not cause any side effect.
  always_comb begin
    dec.pc                = in_pc;
    dec.write_en          = dec_rd_writes & (rd != 5'd0) & !dec_illegal;
    dec.write_addr        = rd;
    dec.read_addr1        = dec_rs1;
    dec.read_addr2        = in_inst[24:20];
    dec.immediate         = dec_imm;
    dec.mem_write_en      = dec_store & !dec_illegal;
    dec.mem_read_en       = dec_load & !dec_illegal;
    dec.funct3            = funct3;
    dec.funct7            = funct7;
    dec.alu_opcode        = dec_alu_op;
    dec.alu_src2_from_imm = dec_src2_imm;
    dec.alu_src1_from_pc  = dec_src1_pc;
    dec.branch_inst       = dec_branch & !dec_illegal;
    dec.jump_inst         = dec_jump & !dec_illegal;
    dec.illegal           = dec_illegal;
  end

  // ---------------------------------------------------------------------
  // Handshake and storage
  // ---------------------------------------------------------------------
  beat_t out_q;
  beat_t out_d;
  logic  out_valid_q;
  logic  out_valid_d;
  logic  accept;

  // A beat presented during flush is dropped together with the held ones.
  assign accept = in_valid & in_ready & !flush;

  generate
    if (SKID != 0) begin : g_skid
      beat_t skid_q;
      beat_t skid_d;
      logic  skid_valid_q;
      logic  skid_valid_d;

      assign in_ready = !skid_valid_q;

      // Next state: skid drains first so that beat order is kept.
      always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
          if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
          end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
          end
        end else if (accept) begin
          skid_d       = dec;
          skid_valid_d = 1'b1;
        end
      end

      // Output and skid registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q        <= '0;
          out_valid_q  <= 1'b0;
          skid_q       <= '0;
          skid_valid_q <= 1'b0;
        end else begin
          out_q        <= out_d;
          out_valid_q  <= out_valid_d;
          skid_q       <= skid_d;
          skid_valid_q <= skid_valid_d;
        end
      end
    end else begin : g_noskid
      assign in_ready = !out_valid_q | out_ready;

      // Next state: the output register reloads whenever it is free.
      always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
          out_valid_d = 1'b0;
        end else if (in_ready) begin
          out_valid_d = accept;
          if (accept) begin
            out_d = dec;
          end
        end
      end

      // Output register.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_q       <= out_d;
          out_valid_q <= out_valid_d;
        end
      end
    end
  endgenerate

  assign out_valid             = out_valid_q;
  assign out_pc                = out_q.pc;
  assign out_write_en          = out_q.write_en;
  assign out_write_addr        = out_q.write_addr;
  assign out_read_addr1        = out_q.read_addr1;
  assign out_read_addr2        = out_q.read_addr2;
  assign out_immediate         = out_q.immediate;
  assign out_mem_write_en      = out_q.mem_write_en;
  assign out_mem_read_en       = out_q.mem_read_en;
  assign out_funct3            = out_q.funct3;
  assign out_funct7            = out_q.funct7;
  assign out_alu_opcode        = out_q.alu_opcode;
  assign out_alu_src2_from_imm = out_q.alu_src2_from_imm;
  assign out_alu_src1_from_pc  = out_q.alu_src1_from_pc;
  assign out_branch_inst       = out_q.branch_inst;
  assign out_jump_inst         = out_q.jump_inst;
  assign out_illegal           = out_q.illegal;

endmodule
